// File: rtl/if_fetch_pkg.sv
// Shared encodings and widths for the instruction-fetch stage.
// Reset level, stall levels, bus widths and FSM state codes.
package if_fetch_pkg;

  localparam logic RST_ENABLE = 1'b1;
  localparam logic STOP       = 1'b1;
  localparam logic NO_STOP    = 1'b0;

  localparam int STOP_W      = 6;
  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  localparam logic [INST_W-1:0]      ZERO_WORD  = '0;
  localparam logic [INST_ADDR_W-1:0] INITIAL_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_BOOT = 2'b00,
    IF_REQ  = 2'b01,
    IF_HOLD = 2'b10,
    IF_ADEL = 2'b11
  } if_state_e;

  function automatic logic [INST_ADDR_W-1:0] align_pc(
    input logic [INST_ADDR_W-1:0] a
  );
    return {a[INST_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch: PC, req/ack fetch FSM and delayed branch redirect.
// IF_ADEL_EN adds a misaligned-fetch exception in place of the request.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC = INITIAL_PC,
  parameter int unsigned            PC_STEP  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STOP_W-1:0]      stall,
  input  logic                   branch_flag_i,
  input  logic [INST_ADDR_W-1:0] branch_target_i,
  output logic                   inst_req_o,
  output logic [INST_ADDR_W-1:0] inst_addr_o,
  input  logic                   inst_ack_i,
  input  logic [INST_W-1:0]      inst_rdata_i,
  output logic [INST_ADDR_W-1:0] if_pc_o,
  output logic [INST_W-1:0]      if_inst_o,
  output logic                   stallreq_o
`ifdef IF_ADEL_EN
  ,
  output logic                   if_excp_adel_o
`endif
);

  if_state_e state;

  logic [INST_ADDR_W-1:0] pc;
  logic [INST_ADDR_W-1:0] redir_pc;
  logic [INST_ADDR_W-1:0] next_pc;
  logic [INST_ADDR_W-1:0] issue_addr;
  logic [INST_ADDR_W-1:0] tgt;
  logic                   redir_valid;
  logic                   run;
  logic                   issue;
  logic                   consume;
  logic                   bad_addr;
  logic                   stall_unused;

  assign run     = (stall[0] == NO_STOP);
  assign next_pc = redir_valid ? redir_pc
                 : pc + INST_ADDR_W'(PC_STEP);

  assign stallreq_o = (state == IF_REQ) & ~inst_ack_i;

`ifdef IF_ADEL_EN
  assign tgt          = branch_target_i;
  assign bad_addr     = (issue_addr[1:0] != 2'b00);
  assign stall_unused = &{1'b0, stall[STOP_W-1:1]};
`else
  // Without the exception path a misaligned target can never be fetched.
  assign tgt          = align_pc(branch_target_i);
  assign bad_addr     = 1'b0;
  assign stall_unused = &{1'b0, stall[STOP_W-1:1],
                          branch_target_i[1:0]};
`endif

  always_comb begin
    issue      = 1'b0;
    consume    = 1'b0;
    issue_addr = next_pc;
    unique case (state)
      IF_BOOT: begin
        issue      = 1'b1;
        issue_addr = pc;
      end
      IF_REQ: begin
        if (inst_ack_i && run) begin
          issue   = 1'b1;
          consume = 1'b1;
        end
      end
      IF_HOLD: begin
        if (run) begin
          issue   = 1'b1;
          consume = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state       <= IF_BOOT;
      pc          <= RESET_PC;
      redir_pc    <= '0;
      redir_valid <= 1'b0;
      inst_req_o  <= 1'b0;
      inst_addr_o <= '0;
      if_pc_o     <= '0;
      if_inst_o   <= ZERO_WORD;
`ifdef IF_ADEL_EN
      if_excp_adel_o <= 1'b0;
`endif
    end else begin
      // A branch in the consuming cycle wins: it targets the next update.
      if (branch_flag_i) begin
        redir_pc    <= tgt;
        redir_valid <= 1'b1;
      end else if (consume) begin
        redir_valid <= 1'b0;
      end

      if (state == IF_REQ && inst_ack_i) begin
        if_pc_o   <= pc;
        if_inst_o <= inst_rdata_i;
`ifdef IF_ADEL_EN
        if_excp_adel_o <= 1'b0;
`endif
        if (!run) begin
          state      <= IF_HOLD;
          inst_req_o <= 1'b0;
        end
      end

      if (state == IF_ADEL) begin
        if_pc_o   <= pc;
        if_inst_o <= ZERO_WORD;
`ifdef IF_ADEL_EN
        if_excp_adel_o <= 1'b1;
`endif
        state <= IF_HOLD;
      end

      if (issue) begin
        pc <= issue_addr;
        if (bad_addr) begin
          inst_req_o <= 1'b0;
          state      <= IF_ADEL;
        end else begin
          inst_req_o  <= 1'b1;
          inst_addr_o <= issue_addr;
          state       <= IF_REQ;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed-vector bench for if_fetch: one table row per clock cycle.
// Inputs are driven after the falling edge; outputs are checked 1ns later.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_ack_i;
  logic [31:0] inst_rdata_i;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        stallreq_o;
`ifdef IF_ADEL_EN
  logic        if_excp_adel_o;
`endif

  if_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .inst_req_o      (inst_req_o),
    .inst_addr_o     (inst_addr_o),
    .inst_ack_i      (inst_ack_i),
    .inst_rdata_i    (inst_rdata_i),
    .if_pc_o         (if_pc_o),
    .if_inst_o       (if_inst_o),
    .stallreq_o      (stallreq_o)
`ifdef IF_ADEL_EN
    ,
    .if_excp_adel_o  (if_excp_adel_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        s;
    logic        b;
    logic [31:0] t;
    logic        a;
    logic [31:0] d;
    logic        q;
    logic [31:0] ea;
    logic [31:0] ep;
    logic [31:0] ei;
    logic        sr;
    logic        ex;
  } vec_t;

  vec_t tbl [64];
  int   n;
  int   errors;
  int   checks;

  task automatic add(
    input logic r, input logic s, input logic b,
    input logic [31:0] t, input logic a, input logic [31:0] d,
    input logic q, input logic [31:0] ea, input logic [31:0] ep,
    input logic [31:0] ei, input logic sr, input logic ex
  );
    tbl[n] = '{r, s, b, t, a, d, q, ea, ep, ei, sr, ex};
    n++;
  endtask

  task automatic chk(
    input int row, input string name,
    input logic [31:0] got, input logic [31:0] want
  );
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL row %0d %s: got %h want %h",
               row, name, got, want);
    end
  endtask

  task automatic drive(
    input logic r, input logic s, input logic b,
    input logic [31:0] t, input logic a, input logic [31:0] d
  );
    rst             = r;
    stall           = {5'b0, s};
    branch_flag_i   = b;
    branch_target_i = t;
    inst_ack_i      = a;
    inst_rdata_i    = d;
  endtask

  initial begin
    bit found;
    errors = 0;
    checks = 0;
    n      = 0;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    //  r  s  b  target        ack data          req addr          pc            inst          sr ex
    add(1, 0, 0, 32'h0,        0, 32'h0,         0, 32'h0,         32'h0,        32'h0,        0, 0);
    add(0, 0, 0, 32'h0,        0, 32'h0,         0, 32'h0,         32'h0,        32'h0,        0, 0);
    add(0, 0, 0, 32'h0,        1, 32'hC0DE_0000, 1, 32'h0,         32'h0,        32'h0,        0, 0);
    add(0, 0, 0, 32'h0,        1, 32'hC0DE_0004, 1, 32'h4,         32'h0,        32'hC0DE_0000, 0, 0);
    add(0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h8,         32'h4,        32'hC0DE_0004, 1, 0);
    add(0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h8,         32'h4,        32'hC0DE_0004, 1, 0);
    add(0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h8,         32'h4,        32'hC0DE_0004, 1, 0);
    add(0, 0, 0, 32'h0,        1, 32'hC0DE_0008, 1, 32'h8,         32'h4,        32'hC0DE_0004, 0, 0);
    add(0, 0, 0, 32'h0,        1, 32'hC0DE_000C, 1, 32'hC,         32'h8,        32'hC0DE_0008, 0, 0);
    add(0, 0, 0, 32'h0,        1, 32'hC0DE_0010, 1, 32'h10,        32'hC,        32'hC0DE_000C, 0, 0);
    add(0, 0, 1, 32'h100,      0, 32'h0,         1, 32'h14,        32'h10,       32'hC0DE_0010, 1, 0);
    add(0, 0, 0, 32'h0,        1, 32'hC0DE_0014, 1, 32'h14,        32'h10,       32'hC0DE_0010, 0, 0);
    add(0, 0, 0, 32'h0,        1, 32'hC0DE_0100, 1, 32'h100,       32'h14,       32'hC0DE_0014, 0, 0);
    add(0, 0, 1, 32'h20,       1, 32'hC0DE_0104, 1, 32'h104,       32'h100,      32'hC0DE_0100, 0, 0);
    add(0, 0, 0, 32'h0,        1, 32'hC0DE_0108, 1, 32'h108,       32'h104,      32'hC0DE_0104, 0, 0);
    add(0, 1, 0, 32'h0,        1, 32'hC0DE_0020, 1, 32'h20,        32'h108,      32'hC0DE_0108, 0, 0);
    add(0, 1, 0, 32'h0,        0, 32'h0,         0, 32'h20,        32'h20,       32'hC0DE_0020, 0, 0);
    add(0, 1, 0, 32'h0,        0, 32'h0,         0, 32'h20,        32'h20,       32'hC0DE_0020, 0, 0);
    add(0, 1, 0, 32'h0,        0, 32'h0,         0, 32'h20,        32'h20,       32'hC0DE_0020, 0, 0);
    add(0, 0, 0, 32'h0,        0, 32'h0,         0, 32'h20,        32'h20,       32'hC0DE_0020, 0, 0);
    add(0, 0, 0, 32'h0,        1, 32'hC0DE_0024, 1, 32'h24,        32'h20,       32'hC0DE_0020, 0, 0);
    add(0, 1, 0, 32'h0,        0, 32'h0,         1, 32'h28,        32'h24,       32'hC0DE_0024, 1, 0);
    add(0, 0, 0, 32'h0,        1, 32'hC0DE_0028, 1, 32'h28,        32'h24,       32'hC0DE_0024, 0, 0);
    add(0, 0, 0, 32'h0,        1, 32'hC0DE_002C, 1, 32'h2C,        32'h28,       32'hC0DE_0028, 0, 0);
    add(0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h30,        32'h2C,       32'hC0DE_002C, 1, 0);
    add(1, 0, 0, 32'h0,        1, 32'hC0DE_0030, 1, 32'h30,        32'h2C,       32'hC0DE_002C, 0, 0);
    add(0, 0, 0, 32'h0,        0, 32'h0,         0, 32'h0,         32'h0,        32'h0,        0, 0);
    add(0, 0, 0, 32'h0,        1, 32'hC0DE_0000, 1, 32'h0,         32'h0,        32'h0,        0, 0);
    add(0, 0, 1, 32'h102,      0, 32'h0,         1, 32'h4,         32'h0,        32'hC0DE_0000, 1, 0);
    add(0, 0, 0, 32'h0,        1, 32'hC0DE_0004, 1, 32'h4,         32'h0,        32'hC0DE_0000, 0, 0);
`ifdef IF_ADEL_EN
    add(0, 0, 0, 32'h0,        0, 32'h0,         0, 32'h4,         32'h4,        32'hC0DE_0004, 0, 0);
    add(0, 1, 0, 32'h0,        0, 32'h0,         0, 32'h4,         32'h102,      32'h0,        0, 1);
    add(0, 1, 0, 32'h0,        0, 32'h0,         0, 32'h4,         32'h102,      32'h0,        0, 1);
`else
    add(0, 0, 1, 32'hFFFF_FFFC, 1, 32'hC0DE_0100, 1, 32'h100,      32'h4,        32'hC0DE_0004, 0, 0);
    add(0, 0, 0, 32'h0,        1, 32'hC0DE_0104, 1, 32'h104,       32'h100,      32'hC0DE_0100, 0, 0);
    add(0, 0, 0, 32'h0,        1, 32'hDEAD_BEEF, 1, 32'hFFFF_FFFC, 32'h104,      32'hC0DE_0104, 0, 0);
    add(0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h0,         32'hFFFF_FFFC, 32'hDEAD_BEEF, 1, 0);
`endif

    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive(tbl[i].r, tbl[i].s, tbl[i].b,
            tbl[i].t, tbl[i].a, tbl[i].d);
      #1;
      chk(i, "inst_req_o", 32'(inst_req_o), 32'(tbl[i].q));
      chk(i, "inst_addr_o", inst_addr_o, tbl[i].ea);
      chk(i, "if_pc_o", if_pc_o, tbl[i].ep);
      chk(i, "if_inst_o", if_inst_o, tbl[i].ei);
      chk(i, "stallreq_o", 32'(stallreq_o), 32'(tbl[i].sr));
`ifdef IF_ADEL_EN
      chk(i, "if_excp_adel_o", 32'(if_excp_adel_o),
          32'(tbl[i].ex));
`endif
    end

    // Held reset with acks arriving: outputs stay at reset values.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1234_5678);
      #1;
      if (k > 0) begin
        chk(100 + k, "rst inst_req_o", 32'(inst_req_o), 32'h0);
        chk(100 + k, "rst inst_addr_o", inst_addr_o, 32'h0);
        chk(100 + k, "rst if_pc_o", if_pc_o, 32'h0);
        chk(100 + k, "rst if_inst_o", if_inst_o, 32'h0);
        chk(100 + k, "rst stallreq_o", 32'(stallreq_o), 32'h0);
      end
    end

    // First request after release must come within a short budget.
    found = 1'b0;
    for (int k = 0; k < 5 && !found; k++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      #1;
      if (inst_req_o) found = 1'b1;
    end
    chk(200, "first req seen", 32'(found), 32'h1);
    chk(201, "first req addr", inst_addr_o, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
